change_dispense_ctrl: RTL and testbench

CHANGE_DISPENSE_CTRL -- requirements
Module: change_dispense_ctrl

---
 rtl/change_dispense_ctrl.sv | 158 +++++++++++++++
 tb/tb_change_dispense_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispense_ctrl.sv
// Change dispenser controller: pays out a balance as greedy 10/5/1 coins
// through a req/ack handshake with a coin hopper, with hopper timeout fault.
//
// state  | meaning
// IDLE   | waiting for start
// SELECT | choose next coin denomination (greedy)
// REQ    | disp_req high, waiting for disp_ack or timeout
// GAP    | idle spacing between coins
// DONE   | one-cycle done pulse
// FAULT  | hopper timed out, held until clr_fault
module change_dispense_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned GAP     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] balance,
  input  logic       disp_ack,
  input  logic       clr_fault,
  output logic       disp_req,
  output logic [1:0] disp_den,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [7:0] remain,
  output logic [4:0] cnt10,
  output logic [1:0] cnt5,
  output logic [2:0] cnt1
);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_REQ, S_GAP, S_DONE, S_FAULT
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
  localparam logic [3:0] GAP_LAST  = 4'(GAP - 1);

  localparam logic [1:0] DEN_1  = 2'b00;
  localparam logic [1:0] DEN_5  = 2'b01;
  localparam logic [1:0] DEN_10 = 2'b10;

  state_t     state_q, state_d;
  logic [7:0] remain_q, remain_d;
  logic [4:0] cnt10_q, cnt10_d;
  logic [1:0] cnt5_q, cnt5_d;
  logic [2:0] cnt1_q, cnt1_d;
  logic [1:0] den_q, den_d;
  logic [7:0] wait_q, wait_d;
  logic [3:0] gap_q, gap_d;
  logic [7:0] coin_val;

  // Value of the coin currently latched for the hopper.
  always_comb begin
    coin_val = 8'd1;
    case (den_q)
      DEN_10:  coin_val = 8'd10;
      DEN_5:   coin_val = 8'd5;
      default: coin_val = 8'd1;
    endcase
  end

  // Next-state and datapath update; every register holds unless its state acts on it.
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    cnt10_d  = cnt10_q;
    cnt5_d   = cnt5_q;
    cnt1_d   = cnt1_q;
    den_d    = den_q;
    wait_d   = wait_q;
    gap_d    = gap_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          remain_d = balance;
          cnt10_d  = '0;
          cnt5_d   = '0;
          cnt1_d   = '0;
          state_d  = (balance == 8'd0) ? S_DONE : S_SELECT;
        end
      end
      S_SELECT: begin
        if (remain_q >= 8'd10)     den_d = DEN_10;
        else if (remain_q >= 8'd5) den_d = DEN_5;
        else                       den_d = DEN_1;
        wait_d  = '0;
        state_d = S_REQ;
      end
      S_REQ: begin
        if (disp_ack) begin
          remain_d = remain_q - coin_val;
          case (den_q)
            DEN_10:  cnt10_d = cnt10_q + 5'd1;
            DEN_5:   cnt5_d  = cnt5_q + 2'd1;
            default: cnt1_d  = cnt1_q + 3'd1;
          endcase
          gap_d   = GAP_LAST;
          state_d = S_GAP;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_FAULT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_GAP: begin
        if (gap_q == 4'd0) state_d = (remain_q == 8'd0) ? S_DONE : S_SELECT;
        else               gap_d   = gap_q - 4'd1;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_FAULT: begin
        if (clr_fault) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      remain_q <= '0;
      cnt10_q  <= '0;
      cnt5_q   <= '0;
      cnt1_q   <= '0;
      den_q    <= DEN_1;
      wait_q   <= '0;
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      cnt10_q  <= cnt10_d;
      cnt5_q   <= cnt5_d;
      cnt1_q   <= cnt1_d;
      den_q    <= den_d;
      wait_q   <= wait_d;
      gap_q    <= gap_d;
    end
  end

  // Status outputs decode straight from the state so reset clears them without a clock.
  always_comb begin
    disp_req = (state_q == S_REQ);
    busy     = (state_q == S_SELECT) || (state_q == S_REQ) ||
               (state_q == S_GAP)    || (state_q == S_FAULT);
    done     = (state_q == S_DONE);
    fault    = (state_q == S_FAULT);
  end

  assign disp_den = den_q;
  assign remain   = remain_q;
  assign cnt10    = cnt10_q;
  assign cnt5     = cnt5_q;
  assign cnt1     = cnt1_q;

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// Directed bench for change_dispense_ctrl (TIMEOUT=8, GAP=4).
module tb_change_dispense_ctrl;

  logic       clk, rst, start, disp_ack, clr_fault;
  logic [7:0] balance;
  logic       disp_req, busy, done, fault;
  logic [1:0] disp_den;
  logic [7:0] remain;
  logic [4:0] cnt10;
  logic [1:0] cnt5;
  logic [2:0] cnt1;

  int n_assert = 0;
  int n_fail   = 0;
  int coins[$];
  int done_cnt;
  int req_cycles;
  int tens;

  change_dispense_ctrl #(.TIMEOUT(8), .GAP(4)) dut (
    .clk(clk), .rst(rst), .start(start), .balance(balance),
    .disp_ack(disp_ack), .clr_fault(clr_fault),
    .disp_req(disp_req), .disp_den(disp_den), .busy(busy), .done(done),
    .fault(fault), .remain(remain), .cnt10(cnt10), .cnt5(cnt5), .cnt1(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"},    32'(disp_req), 0);
    chk({tag, "_den"},    32'(disp_den), 0);
    chk({tag, "_busy"},   32'(busy),     0);
    chk({tag, "_done"},   32'(done),     0);
    chk({tag, "_fault"},  32'(fault),    0);
    chk({tag, "_remain"}, 32'(remain),   0);
    chk({tag, "_cnt10"},  32'(cnt10),    0);
    chk({tag, "_cnt5"},   32'(cnt5),     0);
    chk({tag, "_cnt1"},   32'(cnt1),     0);
  endtask

  // Acts as the hopper: acks after ack_delay REQ cycles (0 = ack held high),
  // records each acknowledged denomination and counts done pulses.
  task automatic run_hopper(input int ack_delay, input int budget);
    int req_cnt;
    int after;
    req_cnt  = 0;
    after    = -1;
    coins.delete();
    done_cnt = 0;
    for (int i = 0; i < budget; i++) begin
      if (done) done_cnt++;
      if (done && after < 0) after = 2;
      if (disp_req) begin
        req_cnt++;
        disp_ack = (ack_delay == 0) || (req_cnt > ack_delay);
        if (disp_ack) coins.push_back(int'(disp_den));
      end else begin
        req_cnt  = 0;
        disp_ack = (ack_delay == 0);
      end
      if (after == 0) break;
      if (after > 0) after--;
      tick();
    end
    chk("hopper_done_reached", 32'(after), 0);
    disp_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; balance = '0; disp_ack = 1'b0; clr_fault = 1'b0;
    #1;
    chk_all_zero("reset");
    tick(); tick();
    rst = 1'b0;
    tick();

    // balance 17, ack held: 10,5,1,1
    start = 1'b1; balance = 8'd17; disp_ack = 1'b1;
    tick();
    start = 1'b0;
    chk("b17_busy_n1", 32'(busy), 1);
    chk("b17_req_n1", 32'(disp_req), 0);
    tick();
    chk("b17_req_n2", 32'(disp_req), 1);
    chk("b17_den_first", 32'(disp_den), 2);
    run_hopper(0, 200);
    chk("b17_ncoins", 32'(coins.size()), 4);
    if (coins.size() == 4) begin
      chk("b17_coin0", 32'(coins[0]), 2);
      chk("b17_coin1", 32'(coins[1]), 1);
      chk("b17_coin2", 32'(coins[2]), 0);
      chk("b17_coin3", 32'(coins[3]), 0);
    end
    chk("b17_cnt10", 32'(cnt10), 1);
    chk("b17_cnt5", 32'(cnt5), 1);
    chk("b17_cnt1", 32'(cnt1), 2);
    chk("b17_remain", 32'(remain), 0);
    chk("b17_done_pulses", 32'(done_cnt), 1);
    chk("b17_idle_busy", 32'(busy), 0);

    // balance 0: immediate done, no request
    tick();
    start = 1'b1; balance = 8'd0;
    tick();
    start = 1'b0;
    chk("b0_done_n1", 32'(done), 1);
    chk("b0_busy_n1", 32'(busy), 0);
    chk("b0_req_n1", 32'(disp_req), 0);
    tick();
    chk("b0_done_n2", 32'(done), 0);
    chk("b0_req_n2", 32'(disp_req), 0);

    // timeout: balance 5, no ack
    tick();
    start = 1'b1; balance = 8'd5;
    tick();
    start = 1'b0;
    tick();
    req_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (disp_req) req_cycles++;
      else if (req_cycles > 0) break;
      tick();
    end
    chk("to_req_cycles", 32'(req_cycles), 8);
    chk("to_fault", 32'(fault), 1);
    chk("to_req_low", 32'(disp_req), 0);
    chk("to_busy", 32'(busy), 1);
    chk("to_remain", 32'(remain), 5);
    chk("to_cnt5", 32'(cnt5), 0);
    start = 1'b1; balance = 8'd9; disp_ack = 1'b1;
    tick();
    start = 1'b0; disp_ack = 1'b0;
    tick();
    chk("to_start_ignored_remain", 32'(remain), 5);
    chk("to_still_fault", 32'(fault), 1);
    clr_fault = 1'b1;
    tick();
    clr_fault = 1'b0;
    chk("clr_fault", 32'(fault), 0);
    chk("clr_busy", 32'(busy), 0);
    chk("clr_no_done", 32'(done), 0);

    // balance 255, ack 3 cycles late
    tick();
    start = 1'b1; balance = 8'd255;
    tick();
    start = 1'b0;
    run_hopper(3, 2000);
    chk("b255_ncoins", 32'(coins.size()), 26);
    tens = 0;
    foreach (coins[k]) if (k < 25 && coins[k] == 2) tens++;
    chk("b255_first25_tens", 32'(tens), 25);
    if (coins.size() == 26) chk("b255_last_five", 32'(coins[25]), 1);
    chk("b255_cnt10", 32'(cnt10), 25);
    chk("b255_cnt5", 32'(cnt5), 1);
    chk("b255_cnt1", 32'(cnt1), 0);
    chk("b255_remain", 32'(remain), 0);
    chk("b255_done_pulses", 32'(done_cnt), 1);

    // balance 9, second start during GAP ignored
    tick();
    start = 1'b1; balance = 8'd9;
    tick();
    start = 1'b0;
    tick();
    chk("b9_den5", 32'(disp_den), 1);
    disp_ack = 1'b1;
    tick();
    chk("b9_gap_remain", 32'(remain), 4);
    start = 1'b1; balance = 8'd50;
    tick();
    start = 1'b0;
    chk("b9_restart_ignored", 32'(remain), 4);
    chk("b9_restart_busy", 32'(busy), 1);
    run_hopper(0, 200);
    chk("b9_ncoins", 32'(coins.size()), 4);
    chk("b9_cnt5", 32'(cnt5), 1);
    chk("b9_cnt1", 32'(cnt1), 4);
    chk("b9_cnt10", 32'(cnt10), 0);
    chk("b9_remain", 32'(remain), 0);

    // async reset while disp_req is high
    tick();
    start = 1'b1; balance = 8'd20;
    tick();
    start = 1'b0;
    tick();
    chk("rst_mid_req_before", 32'(disp_req), 1);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("rst_mid");
    tick();
    rst = 1'b0;
    tick();

    // first start after reset: balance 6 -> 5,1
    start = 1'b1; balance = 8'd6;
    tick();
    start = 1'b0;
    chk("post_rst_busy", 32'(busy), 1);
    run_hopper(0, 200);
    chk("post_rst_cnt5", 32'(cnt5), 1);
    chk("post_rst_cnt1", 32'(cnt1), 1);
    chk("post_rst_remain", 32'(remain), 0);
    chk("post_rst_done_pulses", 32'(done_cnt), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
